// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, reads one word per cycle from a
// registered-output instruction memory and buffers {PC+4, instr} ahead of IF/ID.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic             im_req,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_dout,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc_plus4,
  output logic [31:0]      fetch_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } entry_t;

  entry_t            fifo [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              resp_valid;
  logic [31:0]       resp_pc;
  logic              push, pop;
  logic              unused_pc_lo;

  assign unused_pc_lo = ^redirect_pc[1:0];

  // Counting the in-flight word against capacity means a returning word always has a slot.
  assign im_req    = rst & ~redirect &
                     (({1'b0, count} + (CW+1)'(resp_valid)) < (CW+1)'(DEPTH));
  assign im_addr   = fetch_pc[IM_AW+1:2];
  assign push      = resp_valid & ~redirect;
  assign pop       = out_valid & out_ready & ~redirect;
  assign out_valid = (count != '0);
  assign out_instr    = fifo[rd_ptr].instr;
  assign out_pc_plus4 = fifo[rd_ptr].pc_plus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc   <= RESET_PC;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_pc    <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (redirect) begin
      // Flush everything buffered and the word still coming back from memory.
      fetch_pc   <= {redirect_pc[31:2], 2'b00};
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= im_req;
      if (im_req) begin
        resp_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        fifo[wr_ptr] <= '{pc_plus4: resp_pc + 32'd4, instr: im_dout};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboarded bench for if_fetch_queue: expected heads are the sequential PC stream
// from the latest reset/redirect target, popped by a monitor on every handshake.
module tb_if_fetch_queue;
  localparam int DEPTH = 4;
  localparam int IM_AW = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              im_req;
  logic [IM_AW-1:0]  im_addr;
  logic [31:0]       im_dout = '0;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              out_ready;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc_plus4;
  logic [31:0]       fetch_pc;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .IM_AW(IM_AW)) dut (
    .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_dout(im_dout),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_ready(out_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc_plus4(out_pc_plus4),
    .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  // Registered-output instruction memory.
  logic [31:0] mem [1024];
  always @(posedge clk) if (im_req) im_dout <= mem[im_addr];

  int checks = 0;
  int failures = 0;
  int hs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] gen_pc;

  function automatic void gen_fill();
    exp_t e;
    while (exp_q.size() < 32) begin
      e.pc4   = gen_pc + 32'd4;
      e.instr = mem[gen_pc[11:2]];
      exp_q.push_back(e);
      gen_pc  = gen_pc + 32'd4;
    end
  endfunction

  function automatic void reseed(input logic [31:0] t);
    exp_q.delete();
    gen_pc = {t[31:2], 2'b00};
    gen_fill();
  endfunction

  // Monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b1 && redirect === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      hs++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=handshake expected=none");
      end else begin
        mon_e = exp_q.pop_front();
        chk("head_pc_plus4", out_pc_plus4, mon_e.pc4);
        chk("head_instr", out_instr, mon_e.instr);
        gen_fill();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    reseed(t);
    step();
    redirect    = 1'b0;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps;
    int hs0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc4", out_pc_plus4, 0);
    chk("rst_im_req", im_req, 0);
    chk("rst_fetch_pc", fetch_pc, 0);

    // Reset release and first-word latency
    repeat (2) @(posedge clk);
    #1;
    reseed(32'h0);
    rst = 1'b1; out_ready = 1'b1;
    #1;
    chk("rel_im_addr", im_addr, 0);
    chk("rel_im_req", im_req, 1);
    step(); chk("lat_edge1_valid", out_valid, 0);
    step(); chk("lat_edge2_valid", out_valid, 1);

    // Streaming
    gaps = 0;
    repeat (20) begin step(); if (!out_valid) gaps++; end
    chk("stream_gaps", gaps, 0);

    // Backpressure: fills, stops requesting, then drains with no loss
    out_ready = 1'b0;
    repeat (10) step();
    chk("bp_im_req", im_req, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    gaps = 0;
    repeat (12) begin step(); if (!out_valid) gaps++; end
    chk("bp_gap_le1", (gaps > 1), 0);

    // Reset mid-stream takes effect without a clock edge
    out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    reseed(32'h0);
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_instr", out_instr, 0);
    chk("mid_rst_pc4", out_pc_plus4, 0);
    chk("mid_rst_im_req", im_req, 0);
    chk("mid_rst_fetch_pc", fetch_pc, 0);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rel_im_addr", im_addr, 0);

    // Redirect while full
    repeat (10) step();
    chk("full_im_req", im_req, 0);
    redir(32'h40);
    chk("rd_valid0", out_valid, 0);
    chk("rd_fetch_pc", fetch_pc, 32'h40);
    chk("rd_im_addr", im_addr, 16);
    step(); chk("rd_valid1", out_valid, 0);
    step(); chk("rd_valid2", out_valid, 1);
    out_ready = 1'b1;
    repeat (6) step();

    // Unaligned redirect with out_ready high, crossing the IM address wrap
    redir(32'hFFE);
    chk("ua_fetch_pc", fetch_pc, 32'hFFC);
    chk("ua_im_addr0", im_addr, 10'h3FF);
    step();
    chk("ua_im_addr1", im_addr, 0);
    chk("ua_fetch_pc1", fetch_pc, 32'h1000);
    repeat (6) step();

    // 32-bit PC wrap
    redir(32'hFFFF_FFFC);
    chk("wr_fetch_pc", fetch_pc, 32'hFFFF_FFFC);
    step();
    chk("wr_fetch_pc_wrap", fetch_pc, 0);
    repeat (6) step();

    // Back-to-back redirects: only the last target is fetched
    redir(32'h100);
    redir(32'h200);
    chk("b2b_fetch_pc", fetch_pc, 32'h200);
    step(); step();
    chk("b2b_valid", out_valid, 1);
    repeat (4) step();

    // Randomized traffic
    hs0 = hs;
    repeat (3000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 31) == 0) redir($urandom);
      else step();
    end
    chk("rand_progress", (hs - hs0 > 1000), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
